// File: rtl/poly_mult_result_reducer_pkg.sv
// Shared definitions for the polynomial-multiplier result reducer:
// FSM state encoding and lane/index width helpers.
package poly_mult_result_reducer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam int DEF_D     = 4;
  localparam int DEF_N     = 4;
  localparam int LANE_MULT = 2;

  function automatic int lane_width(input int n);
    return LANE_MULT * n;
  endfunction

  // Keep the index at least one bit wide so D = 1 still elaborates.
  function automatic int idx_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/poly_mult_result_reducer_if.sv
// Product-vector input and reduced-coefficient output handshakes of the reducer.
interface poly_mult_result_reducer_if
  import poly_mult_result_reducer_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int N = DEF_N
);
  localparam int LW = lane_width(N);
  localparam int IW = idx_width(D);

  logic [LW*(2*D-1)-1:0] p;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0]          out_coef;
  logic [IW-1:0]         out_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport slave (
    input  p, in_valid, out_ready,
    output in_ready, out_coef, out_idx, out_valid, out_last
  );

  modport master (
    output p, in_valid, out_ready,
    input  in_ready, out_coef, out_idx, out_valid, out_last
  );

endinterface

// File: rtl/poly_mult_result_reducer_fold.sv
// Folds one upper lane onto one lower lane (negacyclic subtract or cyclic add)
// and reduces the result into [0, Q-1].
module poly_coef_fold_mod #(
  parameter int N          = 4,
  parameter int Q          = 13,
  parameter int NEGACYCLIC = 1
) (
  input  logic [2*N-1:0] lo,
  input  logic [2*N-1:0] hi,
  input  logic           has_upper,
  output logic [N-1:0]   c
);
  localparam int LW = 2 * N;
  localparam int AW = N + 1;
  localparam logic [LW-1:0] Q_LANE = LW'(Q);
  localparam logic [AW-1:0] Q_W    = AW'(Q);

  logic [AW-1:0] a;
  logic [AW-1:0] b;
  logic [AW-1:0] r;

  // Both residues are below Q, so one conditional correction brings the
  // N+1-bit sum or wrapped difference back into range.
  always_comb begin
    a = AW'(lo % Q_LANE);
    b = AW'(hi % Q_LANE);
    r = a;
    if (has_upper) begin
      if (NEGACYCLIC != 0) begin
        r = (a >= b) ? (a - b) : (a - b + Q_W);
      end else begin
        r = a + b;
        if (r >= Q_W) r = r - Q_W;
      end
    end
  end

  assign c = N'(r);

endmodule

// File: rtl/poly_mult_result_reducer.sv
// Captures the 2D-1 product lanes, folds them into D ring coefficients mod Q
// and streams them out one per cycle over a valid/ready handshake.
module poly_mult_result_reducer
  import poly_mult_result_reducer_pkg::*;
#(
  parameter int D          = 4,
  parameter int N          = 4,
  parameter int Q          = 13,
  parameter int NEGACYCLIC = 1
) (
  input logic                      clk,
  input logic                      rst,
  poly_mult_result_reducer_if.slave bus
);
  localparam int LW = lane_width(N);
  localparam int NL = 2 * D - 1;
  localparam int IW = idx_width(D);

  state_t        state_q;
  state_t        state_d;
  logic [LW-1:0] lanes [NL];
  logic [N-1:0]  coef_q;
  logic [N-1:0]  coef_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          valid_q;
  logic          last_q;
  logic          capture;
  logic          load;
  logic          finish;
  logic [LW-1:0] lo;
  logic [LW-1:0] hi;
  logic          has_upper;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && rst) begin
          capture = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        load    = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (last_q) begin
            finish  = 1'b1;
            state_d = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Coefficient being prepared: 0 during PREP, otherwise the one after the
  // beat currently on the output.
  always_comb begin
    idx_d     = (state_q == PREP) ? '0 : idx_q + IW'(1);
    has_upper = (int'(idx_d) < D - 1);
    lo        = '0;
    hi        = '0;
    for (int j = 0; j < NL; j++) begin
      if (j == int'(idx_d))     lo = lanes[j];
      if (j == int'(idx_d) + D) hi = lanes[j];
    end
  end

  poly_coef_fold_mod #(
    .N          (N),
    .Q          (Q),
    .NEGACYCLIC (NEGACYCLIC)
  ) u_fold (
    .lo        (lo),
    .hi        (hi),
    .has_upper (has_upper),
    .c         (coef_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NL; j++) lanes[j] <= '0;
      coef_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (capture) begin
        for (int j = 0; j < NL; j++) lanes[j] <= bus.p[j*LW +: LW];
        idx_q <= '0;
      end
      if (load) begin
        coef_q  <= coef_d;
        idx_q   <= idx_d;
        valid_q <= 1'b1;
        last_q  <= (int'(idx_d) == D - 1);
      end
      if (finish) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && rst;
  assign bus.out_coef  = coef_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_poly_mult_result_reducer.sv
// Directed bench: a negacyclic and a cyclic reducer share the same stimulus
// and are checked against hand-computed coefficient streams.
module tb_poly_mult_result_reducer;
  localparam int D = 4;
  localparam int N = 4;
  localparam int Q = 13;

  // Lane 6 is the leftmost byte, lane 0 the rightmost.
  localparam logic [55:0] P1   = {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [55:0] PMAX = {7{8'd255}};
  localparam logic [55:0] P2   = {8'd200, 8'd12, 8'd3, 8'd250, 8'd7, 8'd100, 8'd20};
  localparam logic [55:0] P3   = {8'd25, 8'd0, 8'd1, 8'd12, 8'd26, 8'd13, 8'd0};

  // Expected beats, beat 0 in the low nibble.
  localparam logic [15:0] E1N = {4'd4, 4'd9, 4'd9, 4'd9};
  localparam logic [15:0] E1C = {4'd4, 4'd10, 4'd8, 4'd6};
  localparam logic [15:0] EMN = {4'd8, 4'd0, 4'd0, 4'd0};
  localparam logic [15:0] EMC = {4'd8, 4'd3, 4'd3, 4'd3};
  localparam logic [15:0] E2N = {4'd3, 4'd2, 4'd10, 4'd4};
  localparam logic [15:0] E2C = {4'd3, 4'd12, 4'd8, 4'd10};
  localparam logic [15:0] E3N = {4'd12, 4'd1, 4'd0, 4'd12};
  localparam logic [15:0] E3C = {4'd12, 4'd12, 4'd0, 4'd1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  poly_mult_result_reducer_if #(.D(D), .N(N)) bus_n ();
  poly_mult_result_reducer_if #(.D(D), .N(N)) bus_c ();

  poly_mult_result_reducer #(.D(D), .N(N), .Q(Q), .NEGACYCLIC(1)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  poly_mult_result_reducer #(.D(D), .N(N), .Q(Q), .NEGACYCLIC(0)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
  );

  logic [1:0]   valid_o;
  logic [1:0]   last_o;
  logic [1:0]   rdy_o;
  logic [N-1:0] coef_o [2];
  logic [1:0]   idx_o  [2];

  assign valid_o   = {bus_c.out_valid, bus_n.out_valid};
  assign last_o    = {bus_c.out_last, bus_n.out_last};
  assign rdy_o     = {bus_c.in_ready, bus_n.in_ready};
  assign coef_o[0] = bus_n.out_coef;
  assign coef_o[1] = bus_c.out_coef;
  assign idx_o[0]  = bus_n.out_idx;
  assign idx_o[1]  = bus_c.out_idx;

  always #5 clk = ~clk;

  function automatic string mname(input int m);
    return (m == 0) ? "neg" : "cyc";
  endfunction

  task automatic drive(input logic [55:0] pv, input logic v, input logic r);
    bus_n.p = pv;  bus_c.p = pv;
    bus_n.in_valid = v;  bus_c.in_valid = v;
    bus_n.out_ready = r; bus_c.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive('0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL reset %s out_valid got=%0b exp=0", mname(m), valid_o[m]); end
      checks++;
      if (last_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL reset %s out_last got=%0b exp=0", mname(m), last_o[m]); end
      checks++;
      if (coef_o[m] !== 4'd0) begin failures++; $display("[TB] FAIL reset %s out_coef got=%0d exp=0", mname(m), coef_o[m]); end
      checks++;
      if (idx_o[m] !== 2'd0) begin failures++; $display("[TB] FAIL reset %s out_idx got=%0d exp=0", mname(m), idx_o[m]); end
      checks++;
      if (rdy_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL reset %s in_ready_low got=%0b exp=0", mname(m), rdy_o[m]); end
    end
    rst = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy_o[m] !== 1'b1) begin failures++; $display("[TB] FAIL reset %s in_ready_released got=%0b exp=1", mname(m), rdy_o[m]); end
    end
  endtask

  // One full polynomial with out_ready high: PREP gap, D consecutive beats,
  // back to IDLE one cycle after the last acceptance.
  task automatic test_stream(input string name, input logic [55:0] pv,
                             input logic [15:0] en, input logic [15:0] ec);
    logic [15:0] e;
    drive(pv, 1'b1, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy_o[m] !== 1'b1) begin failures++; $display("[TB] FAIL %s %s idle_ready got=%0b exp=1", name, mname(m), rdy_o[m]); end
    end
    tick();
    drive(pv, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL %s %s prep_valid got=%0b exp=0", name, mname(m), valid_o[m]); end
      checks++;
      if (rdy_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL %s %s prep_ready got=%0b exp=0", name, mname(m), rdy_o[m]); end
    end
    for (int b = 0; b < D; b++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        e = (m == 0) ? en : ec;
        checks++;
        if (valid_o[m] !== 1'b1) begin failures++; $display("[TB] FAIL %s %s beat%0d valid got=%0b exp=1", name, mname(m), b, valid_o[m]); end
        checks++;
        if (idx_o[m] !== 2'(b)) begin failures++; $display("[TB] FAIL %s %s beat%0d idx got=%0d exp=%0d", name, mname(m), b, idx_o[m], b); end
        checks++;
        if (coef_o[m] !== e[4*b +: 4]) begin failures++; $display("[TB] FAIL %s %s beat%0d coef got=%0d exp=%0d", name, mname(m), b, coef_o[m], e[4*b +: 4]); end
        checks++;
        if (last_o[m] !== (b == D - 1)) begin failures++; $display("[TB] FAIL %s %s beat%0d last got=%0b exp=%0b", name, mname(m), b, last_o[m], (b == D - 1)); end
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL %s %s done_valid got=%0b exp=0", name, mname(m), valid_o[m]); end
      checks++;
      if (rdy_o[m] !== 1'b1) begin failures++; $display("[TB] FAIL %s %s done_ready got=%0b exp=1", name, mname(m), rdy_o[m]); end
    end
  endtask

  task automatic test_backpressure();
    logic [6:0]  pat;
    logic [15:0] e;
    int          eb;
    pat = 7'b1101001;
    drive(P2, 1'b1, 1'b0);
    tick();
    drive(P2, 1'b0, 1'b0);
    tick();
    eb = 0;
    for (int i = 0; i < 7; i++) begin
      for (int m = 0; m < 2; m++) begin
        e = (m == 0) ? E2N : E2C;
        checks++;
        if (valid_o[m] !== 1'b1) begin failures++; $display("[TB] FAIL bp %s cyc%0d valid got=%0b exp=1", mname(m), i, valid_o[m]); end
        checks++;
        if (idx_o[m] !== 2'(eb)) begin failures++; $display("[TB] FAIL bp %s cyc%0d idx got=%0d exp=%0d", mname(m), i, idx_o[m], eb); end
        checks++;
        if (coef_o[m] !== e[4*eb +: 4]) begin failures++; $display("[TB] FAIL bp %s cyc%0d coef got=%0d exp=%0d", mname(m), i, coef_o[m], e[4*eb +: 4]); end
        checks++;
        if (last_o[m] !== (eb == D - 1)) begin failures++; $display("[TB] FAIL bp %s cyc%0d last got=%0b exp=%0b", mname(m), i, last_o[m], (eb == D - 1)); end
      end
      drive(P2, 1'b0, pat[i]);
      tick();
      if (pat[i]) eb++;
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL bp %s done_valid got=%0b exp=0", mname(m), valid_o[m]); end
      checks++;
      if (rdy_o[m] !== 1'b1) begin failures++; $display("[TB] FAIL bp %s done_ready got=%0b exp=1", mname(m), rdy_o[m]); end
    end
  endtask

  // in_valid stays high: P1 is taken first, P2 (already on the bus during
  // the P1 stream) on the first IDLE edge.
  task automatic test_back_to_back();
    logic [15:0] e;
    drive(P1, 1'b1, 1'b1);
    tick();
    drive(P2, 1'b1, 1'b1);
    for (int b = 0; b < D; b++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        e = (m == 0) ? E1N : E1C;
        checks++;
        if (coef_o[m] !== e[4*b +: 4] || idx_o[m] !== 2'(b) || valid_o[m] !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b first %s beat%0d got coef=%0d idx=%0d valid=%0b exp coef=%0d idx=%0d valid=1", mname(m), b, coef_o[m], idx_o[m], valid_o[m], e[4*b +: 4], b);
        end
        checks++;
        if (rdy_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL b2b first %s beat%0d in_ready got=%0b exp=0", mname(m), b, rdy_o[m]); end
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy_o[m] !== 1'b1 || valid_o[m] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b idle %s got ready=%0b valid=%0b exp ready=1 valid=0", mname(m), rdy_o[m], valid_o[m]);
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy_o[m] !== 1'b0 || valid_o[m] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b prep %s got ready=%0b valid=%0b exp ready=0 valid=0", mname(m), rdy_o[m], valid_o[m]);
      end
    end
    drive(P2, 1'b0, 1'b1);
    for (int b = 0; b < D; b++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        e = (m == 0) ? E2N : E2C;
        checks++;
        if (coef_o[m] !== e[4*b +: 4] || idx_o[m] !== 2'(b) || valid_o[m] !== 1'b1) begin
          failures++;
          $display("[TB] FAIL b2b second %s beat%0d got coef=%0d idx=%0d valid=%0b exp coef=%0d idx=%0d valid=1", mname(m), b, coef_o[m], idx_o[m], valid_o[m], e[4*b +: 4], b);
        end
      end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL b2b done %s valid got=%0b exp=0", mname(m), valid_o[m]); end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [15:0] e;
    drive(P3, 1'b1, 1'b1);
    tick();
    drive(P3, 1'b0, 1'b1);
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      e = (m == 0) ? E3N : E3C;
      checks++;
      if (idx_o[m] !== 2'd1 || coef_o[m] !== e[7:4]) begin
        failures++;
        $display("[TB] FAIL rst_mid %s beat1 got idx=%0d coef=%0d exp idx=1 coef=%0d", mname(m), idx_o[m], coef_o[m], e[7:4]);
      end
    end
    rst = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (valid_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid %s valid got=%0b exp=0", mname(m), valid_o[m]); end
      checks++;
      if (rdy_o[m] !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid %s in_ready got=%0b exp=0", mname(m), rdy_o[m]); end
      checks++;
      if (idx_o[m] !== 2'd0 || last_o[m] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rst_mid %s cleared got idx=%0d last=%0b exp idx=0 last=0", mname(m), idx_o[m], last_o[m]);
      end
    end
    rst = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy_o[m] !== 1'b1 || valid_o[m] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rst_mid %s release got ready=%0b valid=%0b exp ready=1 valid=0", mname(m), rdy_o[m], valid_o[m]);
      end
    end
    test_stream("after_reset", P3, E3N, E3C);
  endtask

  initial begin
    test_reset();
    test_stream("basic", P1, E1N, E1C);
    test_stream("max_lanes", PMAX, EMN, EMC);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
